// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame parser: FSM state encodings, error codes
// and the default start-of-frame marker.
package uart_frame_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    // Running checksum is a plain 8-bit wrapping sum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: DEPTH x 8 register array, synchronous write,
// asynchronous read. Contents are not reset.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Length-framed packet parser behind uart_rx: SOF, LEN, payload, checksum.
// Good frames are held for the host to read and ack; bad or stalled frames raise err_tick.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic [7:0] rx_dout,
    input  logic       rx_done_tick,
    output logic       frame_valid,
    output logic [7:0] frame_len,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_last,
    input  logic       frame_ack,
    output logic       err_tick,
    output logic [1:0] err_code,
    output logic       drop_tick,
    output logic [2:0] dbg_state
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS);

    logic [2:0]    state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    wr_ptr_q, wr_ptr_d;
    logic [7:0]    rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_tick_q, err_tick_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          drop_tick_q, drop_tick_d;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          last_int;

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_dout),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    assign frame_valid = (state_q == ST_HOLD);
    assign last_int    = frame_valid && (rd_ptr_q == len_q - 8'd1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tmo_d       = tmo_q;
        err_tick_d  = 1'b0;
        err_code_d  = err_code_q;
        drop_tick_d = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_done_tick && rx_dout == SOF_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_done_tick) begin
                    tmo_d = '0;
                    if (state_q == ST_LEN) begin
                        if (rx_dout == 8'd0 || rx_dout > 8'(MAX_LEN)) begin
                            err_tick_d = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = ST_IDLE;
                        end else begin
                            len_d    = rx_dout;
                            sum_d    = rx_dout;
                            wr_ptr_d = 8'd0;
                            state_d  = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        buf_we = 1'b1;
                        sum_d  = sum8(sum_q, rx_dout);
                        if (wr_ptr_q == len_q - 8'd1) begin
                            state_d = ST_CHK;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 8'd1;
                        end
                    end else begin
                        if (sum8(sum_q, rx_dout) == 8'd0) begin
                            rd_ptr_d = 8'd0;
                            state_d  = ST_HOLD;
                        end else begin
                            err_tick_d = 1'b1;
                            err_code_d = ERR_CHK;
                            state_d    = ST_IDLE;
                        end
                    end
                end else if (s_tick) begin
                    if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
                        tmo_d      = '0;
                        err_tick_d = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                tmo_d       = '0;
                drop_tick_d = rx_done_tick;
                if (frame_ack) begin
                    rd_ptr_d = 8'd0;
                    state_d  = ST_IDLE;
                end else if (rd_en && !last_int) begin
                    rd_ptr_d = rd_ptr_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_ptr_q    <= 8'd0;
            rd_ptr_q    <= 8'd0;
            tmo_q       <= '0;
            err_tick_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tmo_q       <= tmo_d;
            err_tick_q  <= err_tick_d;
            err_code_q  <= err_code_d;
            drop_tick_q <= drop_tick_d;
        end
    end

    assign frame_len = frame_valid ? len_q : 8'd0;
    assign rd_data   = frame_valid ? buf_rdata : 8'd0;
    assign rd_last   = last_int;
    assign err_tick  = err_tick_q;
    assign err_code  = err_code_q;
    assign drop_tick = drop_tick_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: directed byte streams, expected events queued
// by the stimulus and popped by an independent output monitor.
module tb_uart_frame_rx;
    import uart_frame_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] rx_dout = 8'd0;
    logic       rx_done_tick = 1'b0;
    logic       rd_en = 1'b0;
    logic       frame_ack = 1'b0;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       err_tick;
    logic [1:0] err_code;
    logic       drop_tick;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;
    // Event encoding: {kind, value}; kind 1=error(code), 2=drop, 3=frame(len)
    logic [9:0] exp_q[$];
    logic [8:0] rd_q[$];
    logic       fv_prev = 1'b0;
    bq_t        seq;

    uart_frame_rx #(.SOF_BYTE(8'h7E), .MAX_LEN(16), .TIMEOUT_TICKS(640)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .frame_ack    (frame_ack),
        .err_tick     (err_tick),
        .err_code     (err_code),
        .drop_tick    (drop_tick),
        .dbg_state    (dbg_state)
    );

    // Clock and oversample tick
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 s_tick = ~s_tick;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_evt(input string name, input logic [9:0] act);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected event %0h, none expected", name, act);
        end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", name, act, e);
            end
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                fv_prev = 1'b0;
            end else begin
                if (err_tick) pop_evt("err_evt", {2'd1, 6'd0, err_code});
                if (drop_tick) pop_evt("drop_evt", {2'd2, 8'd0});
                if (frame_valid && !fv_prev) pop_evt("frame_evt", {2'd3, frame_len});
                fv_prev = frame_valid;
                if (rd_en && frame_valid) begin
                    checks++;
                    if (rd_q.size() == 0) begin
                        failures++;
                        $display("FAIL rd_data: unexpected read %0h", {rd_last, rd_data});
                    end else begin
                        logic [8:0] e;
                        e = rd_q.pop_front();
                        if ({rd_last, rd_data} !== e) begin
                            failures++;
                            $display("FAIL rd_data: got last=%0b data=%0h expected last=%0b data=%0h",
                                     rd_last, rd_data, e[8], e[7:0]);
                        end
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_dout = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1 rx_done_tick = 1'b0;
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    // Final byte of a good frame: frame_valid must rise exactly one cycle later.
    task automatic send_good_chk(input logic [7:0] c, input logic [7:0] len, input string name);
        exp_q.push_back({2'd3, len});
        chk({name, "_fv_before"}, frame_valid, 1'b0);
        send_byte(c);
        chk({name, "_fv_after"}, frame_valid, 1'b1);
        chk({name, "_len"}, frame_len, len);
    endtask

    task automatic read_frame(input bq_t d);
        foreach (d[i]) rd_q.push_back({(i == d.size() - 1) ? 1'b1 : 1'b0, d[i]});
        rd_q.push_back({1'b1, d[d.size() - 1]});
        @(posedge clk);
        #1 rd_en = 1'b1;
        repeat (d.size() + 1) @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic ack_frame(input string name);
        @(posedge clk);
        #1 frame_ack = 1'b1;
        @(posedge clk);
        #1 frame_ack = 1'b0;
        chk({name, "_fv_acked"}, frame_valid, 1'b0);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_len", frame_len, 8'd0);
        chk("rst_err", {err_tick, err_code, drop_tick}, 4'd0);
        chk("rst_state", dbg_state, ST_IDLE);

        // 1: good 3-byte frame, read with one extra rd_en at the end
        seq = '{8'h7E, 8'h03, 8'h01, 8'h02, 8'h03};
        send_seq(seq);
        send_good_chk(8'hF7, 8'd3, "t1");
        seq = '{8'h01, 8'h02, 8'h03};
        read_frame(seq);
        ack_frame("t1");

        // 2: bad checksum
        exp_q.push_back({2'd1, 6'd0, ERR_CHK});
        seq = '{8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF6};
        send_seq(seq);
        repeat (2) @(posedge clk);
        chk("t2_fv", frame_valid, 1'b0);
        chk("t2_state", dbg_state, ST_IDLE);

        // 3: bad LEN values, then the LEN=MAX_LEN boundary
        exp_q.push_back({2'd1, 6'd0, ERR_LEN});
        seq = '{8'h7E, 8'h00};
        send_seq(seq);
        exp_q.push_back({2'd1, 6'd0, ERR_LEN});
        seq = '{8'h7E, 8'h11};
        send_seq(seq);
        @(negedge clk);
        chk("t3_state", dbg_state, ST_IDLE);
        seq = '{8'h7E, 8'h10};
        send_seq(seq);
        seq = {};
        for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
        send_seq(seq);
        send_good_chk(8'h68, 8'd16, "t3max");
        read_frame(seq);
        ack_frame("t3max");

        // 4: stall mid-payload; timeout must fire on the 640th s_tick
        seq = '{8'h7E, 8'h02, 8'hAA};
        send_seq(seq);
        exp_q.push_back({2'd1, 6'd0, ERR_TMO});
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (s_tick) n++;
            @(negedge clk);
            if (err_tick) break;
        end
        chk("t4_tmo_ticks", n, 640);
        seq = '{8'h7E, 8'h01, 8'h55};
        send_seq(seq);
        send_good_chk(8'hAA, 8'd1, "t4");
        seq = '{8'h55};
        read_frame(seq);
        ack_frame("t4");

        // 5: bytes arriving while a frame is held are dropped
        seq = '{8'h7E, 8'h02, 8'h10, 8'h20};
        send_seq(seq);
        send_good_chk(8'hCE, 8'd2, "t5");
        repeat (4) exp_q.push_back({2'd2, 8'd0});
        seq = '{8'h7E, 8'h01, 8'h55, 8'hAB};
        send_seq(seq);
        @(negedge clk);
        chk("t5_len_kept", frame_len, 8'd2);
        seq = '{8'h10, 8'h20};
        read_frame(seq);
        exp_q.push_back({2'd2, 8'd0});
        @(posedge clk);
        #1;
        frame_ack = 1'b1;
        rx_dout = 8'h7E;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        rx_done_tick = 1'b0;
        chk("t5_fv_acked", frame_valid, 1'b0);
        // Would form a valid frame if the SOF above had not been dropped
        seq = '{8'h01, 8'h55, 8'hAA};
        send_seq(seq);
        @(negedge clk);
        chk("t5_state", dbg_state, ST_IDLE);

        // 6: reset mid-payload, then junk and a good frame
        seq = '{8'h7E, 8'h03, 8'h01};
        send_seq(seq);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_state", dbg_state, ST_IDLE);
        chk("t6_rst_outs", {frame_valid, err_tick, err_code, drop_tick}, 5'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seq = '{8'h12, 8'h34, 8'h7E, 8'h01, 8'h42};
        send_seq(seq);
        send_good_chk(8'hBD, 8'd1, "t6");
        seq = '{8'h42};
        read_frame(seq);
        ack_frame("t6");

        repeat (5) @(posedge clk);
        chk("evt_q_empty", exp_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
